// File: rtl/cpu_datapath_if.sv
// -----------------------------------------------------------------------------
// cpu_datapath_if
//   Bundles the controller <-> datapath connection: instruction and memory
//   inputs, the control strobes produced by the controller FSM, and the
//   decoded fields and results returned by the datapath.
//
//   master : controller side (drives strobes and memory data, reads results)
//   slave  : datapath side  (reads strobes and memory data, drives results)
//
//   instr_in  16   instruction word from memory
//   mdata     16   memory read data (writeback source vsel=00)
//   pc        8    program counter (writeback source vsel=10)
//   loadir         capture instr_in into IR
//   nsel      2    register select: 00=Rn 01=Rd 10=Rm 11=R0
//   vsel      2    writeback source: 00=mdata 01=sximm8 10=pc 11=C
//   write          register file write enable
//   loada/b/c/s    load A, B, C, status
//   asel           ALU A-operand forced to 0
//   bsel           ALU B-operand = sximm5 (shifter bypassed)
//   opcode    3    IR[15:13]
//   op        2    IR[12:11]
//   c_out     16   register C
//   b_out     16   register B
//   status    3    {Z,N,V}
// -----------------------------------------------------------------------------
interface cpu_datapath_if #(
   parameter int WIDTH = 16
);
   logic [15:0]      instr_in;
   logic [WIDTH-1:0] mdata;
   logic [7:0]       pc;
   logic             loadir;
   logic [1:0]       nsel;
   logic [1:0]       vsel;
   logic             write;
   logic             loada;
   logic             loadb;
   logic             loadc;
   logic             loads;
   logic             asel;
   logic             bsel;
   logic [2:0]       opcode;
   logic [1:0]       op;
   logic [WIDTH-1:0] c_out;
   logic [WIDTH-1:0] b_out;
   logic [2:0]       status;

   modport master (
      output instr_in, mdata, pc, loadir, nsel, vsel, write,
             loada, loadb, loadc, loads, asel, bsel,
      input  opcode, op, c_out, b_out, status
   );

   modport slave (
      input  instr_in, mdata, pc, loadir, nsel, vsel, write,
             loada, loadb, loadc, loads, asel, bsel,
      output opcode, op, c_out, b_out, status
   );
endinterface : cpu_datapath_if

// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
//   Execution datapath steered by the controller FSM. Holds the instruction
//   register, the register file, the A/B/C operand/result registers, the
//   shifter, the ALU and the {Z,N,V} status flags.
//
//   clk    rising-edge clock
//   reset  synchronous, active-high; overrides every load/write strobe
//   dp     cpu_datapath_if.slave (strobes in, opcode/op/c_out/b_out/status out)
// -----------------------------------------------------------------------------
module cpu_datapath #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8
) (
   input logic           clk,
   input logic           reset,
   cpu_datapath_if.slave dp
);

   localparam int IDXW = $clog2(NREGS);

   typedef enum logic [1:0] {
      SH_PASS = 2'b00,
      SH_LSL  = 2'b01,
      SH_LSR  = 2'b10,
      SH_ASR  = 2'b11
   } shift_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_MVN = 2'b11
   } alu_op_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [15:0]      ir_q,     ir_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [WIDTH-1:0] c_q,      c_d;
   logic [2:0]       status_q, status_d;
   logic [WIDTH-1:0] rf_q [NREGS];

   // ---------------------------------------------------------------------------
   // Instruction field decode (always from the registered IR)
   // ---------------------------------------------------------------------------
   logic [IDXW-1:0]  rn, rd, rm;
   shift_e           shift;
   alu_op_e          alu_op;
   logic [WIDTH-1:0] sximm8, sximm5;

   assign rn     = ir_q[10:8];
   assign rd     = ir_q[7:5];
   assign rm     = ir_q[2:0];
   assign shift  = shift_e'(ir_q[4:3]);
   assign alu_op = alu_op_e'(ir_q[12:11]);
   assign sximm8 = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
   assign sximm5 = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};

   // ---------------------------------------------------------------------------
   // Register file index, read port and writeback mux
   // ---------------------------------------------------------------------------
   logic [IDXW-1:0]  rf_idx;
   logic [WIDTH-1:0] rf_rdata;
   logic [WIDTH-1:0] wb_data;

   // NOTE: every always_comb output gets a default first so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      rf_idx = rn;
      unique case (dp.nsel)
         2'b00: rf_idx = rn;
         2'b01: rf_idx = rd;
         2'b10: rf_idx = rm;
         2'b11: rf_idx = '0;
      endcase
   end

   // Read sees the pre-edge contents, so a same-cycle write to the register
   // being loaded into A/B leaves A/B with the old value.
   assign rf_rdata = rf_q[rf_idx];

   always_comb begin
      wb_data = dp.mdata;
      unique case (dp.vsel)
         2'b00: wb_data = dp.mdata;
         2'b01: wb_data = sximm8;
         2'b10: wb_data = {{(WIDTH-8){1'b0}}, dp.pc};
         2'b11: wb_data = c_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Shifter on B, operand select
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] b_shifted;
   logic [WIDTH-1:0] ain, bin;

   always_comb begin
      b_shifted = b_q;
      unique case (shift)
         SH_PASS: b_shifted = b_q;
         SH_LSL:  b_shifted = {b_q[WIDTH-2:0], 1'b0};
         SH_LSR:  b_shifted = {1'b0, b_q[WIDTH-1:1]};
         SH_ASR:  b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      endcase
   end

   assign ain = dp.asel ? '0     : a_q;
   assign bin = dp.bsel ? sximm5 : b_shifted;

   // ---------------------------------------------------------------------------
   // ALU and flags
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] alu_res;
   logic             flag_z, flag_n, flag_v;

   always_comb begin
      alu_res = '0;
      flag_v  = 1'b0;
      unique case (alu_op)
         ALU_ADD: begin
            alu_res = ain + bin;
            // Overflow when both operands share a sign the result lacks.
            flag_v  = (ain[WIDTH-1] == bin[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != ain[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res = ain - bin;
            // Overflow when operand signs differ and the result takes B's sign.
            flag_v  = (ain[WIDTH-1] != bin[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != ain[WIDTH-1]);
         end
         ALU_AND: alu_res = ain & bin;
         ALU_MVN: alu_res = ~bin;
      endcase
   end

   assign flag_z = (alu_res == '0);
   assign flag_n = alu_res[WIDTH-1];

   // ---------------------------------------------------------------------------
   // Next-state for the single-word registers; each strobe acts on its own.
   // ---------------------------------------------------------------------------
   always_comb begin
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      status_d = status_q;
      if (dp.loadir) ir_d     = dp.instr_in;
      if (dp.loada)  a_d      = rf_rdata;
      if (dp.loadb)  b_d      = rf_rdata;
      if (dp.loadc)  c_d      = alu_res;
      if (dp.loads)  status_d = {flag_z, flag_n, flag_v};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= '0;
      end else begin
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         status_q <= status_d;
      end
   end

   // NOTE: the register file is deliberately cleared on reset because software
   // relies on R0-R7 reading zero; this keeps it in flops rather than a RAM
   // macro, which is acceptable at eight entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (dp.write) begin
         rf_q[rf_idx] <= wb_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign dp.opcode = ir_q[15:13];
   assign dp.op     = ir_q[12:11];
   assign dp.c_out  = c_q;
   assign dp.b_out  = b_q;
   assign dp.status = status_q;

endmodule : cpu_datapath

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
//   Directed stimulus for cpu_datapath with hand-computed expectations.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_cpu_datapath;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   cpu_datapath_if #(.WIDTH(16)) dp_if ();

   cpu_datapath #(.WIDTH(16), .NREGS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .dp    (dp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act,
                        input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic clear_strobes();
      dp_if.loadir = 1'b0;
      dp_if.write  = 1'b0;
      dp_if.loada  = 1'b0;
      dp_if.loadb  = 1'b0;
      dp_if.loadc  = 1'b0;
      dp_if.loads  = 1'b0;
      dp_if.asel   = 1'b0;
      dp_if.bsel   = 1'b0;
      dp_if.nsel   = 2'b00;
      dp_if.vsel   = 2'b00;
   endtask

   // Apply the currently driven strobes for one edge, then drop them.
   task automatic cycle();
      @(posedge clk);
      #1;
      clear_strobes();
      reset = 1'b0;
   endtask

   task automatic set_ir(input logic [15:0] v);
      dp_if.instr_in = v;
      dp_if.loadir   = 1'b1;
      cycle();
   endtask

   // Point Rn at idx, then write v into it from mdata.
   task automatic wr_reg(input logic [2:0] idx, input logic [15:0] v);
      set_ir({5'b0, idx, 8'h00});
      dp_if.mdata = v;
      dp_if.nsel  = 2'b00;
      dp_if.vsel  = 2'b00;
      dp_if.write = 1'b1;
      cycle();
   endtask

   // Load register idx into B and observe it on b_out.
   task automatic rd_reg(input string tag, input logic [2:0] idx,
                         input logic [15:0] exp);
      set_ir({5'b0, idx, 8'h00});
      dp_if.nsel  = 2'b00;
      dp_if.loadb = 1'b1;
      cycle();
      check(tag, dp_if.b_out, exp);
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      dp_if.instr_in = '0;
      dp_if.mdata    = '0;
      dp_if.pc       = '0;
      clear_strobes();

      // ---- Reset state -------------------------------------------------------
      reset = 1'b1;
      @(posedge clk);
      reset = 1'b1;
      cycle();
      check("rst_opcode", 16'(dp_if.opcode), 16'h0);
      check("rst_op",     16'(dp_if.op),     16'h0);
      check("rst_c",      dp_if.c_out,       16'h0);
      check("rst_b",      dp_if.b_out,       16'h0);
      check("rst_status", 16'(dp_if.status), 16'h0);
      rd_reg("rst_r3", 3'd3, 16'h0);

      // ---- IR only changes on loadir ---------------------------------------
      dp_if.instr_in = 16'hD107;
      cycle();
      check("ir_hold", 16'(dp_if.opcode), 16'h0);

      // ---- MOV immediate -----------------------------------------------------
      set_ir(16'hD107);                 // MOV R1,#7
      check("mov_opcode", 16'(dp_if.opcode), 16'h6);
      check("mov_op",     16'(dp_if.op),     16'h2);
      dp_if.nsel = 2'b00; dp_if.vsel = 2'b01; dp_if.write = 1'b1;
      cycle();
      set_ir(16'hD2FF);                 // MOV R2,#-1
      dp_if.nsel = 2'b00; dp_if.vsel = 2'b01; dp_if.write = 1'b1;
      cycle();
      rd_reg("mov_r1", 3'd1, 16'h0007);
      rd_reg("mov_r2", 3'd2, 16'hFFFF);

      // ---- ADD R3,R1,R2,LSL#1 : 7 + (3<<1) = 13 ------------------------------
      wr_reg(3'd2, 16'h0003);
      set_ir(16'hA16A);                 // Rn=1 Rd=3 shift=01 Rm=2
      dp_if.nsel = 2'b00; dp_if.loada = 1'b1; cycle();
      dp_if.nsel = 2'b10; dp_if.loadb = 1'b1; cycle();
      dp_if.loadc = 1'b1; cycle();
      check("add_c", dp_if.c_out, 16'd13);
      dp_if.nsel = 2'b01; dp_if.vsel = 2'b11; dp_if.write = 1'b1; cycle();
      rd_reg("add_r3", 3'd3, 16'd13);

      // ---- CMP R0,R1 : 0x7FFF - 0xFFFF = 0x8000 -> Z0 N1 V1 ------------------
      wr_reg(3'd0, 16'h7FFF);
      wr_reg(3'd1, 16'hFFFF);
      set_ir(16'hA801);                 // SUB-type, Rn=0 Rm=1
      dp_if.nsel = 2'b00; dp_if.loada = 1'b1; cycle();
      dp_if.nsel = 2'b10; dp_if.loadb = 1'b1; cycle();
      dp_if.loads = 1'b1; cycle();
      check("cmp_status", 16'(dp_if.status), 16'h3);
      check("cmp_c_hold", dp_if.c_out, 16'd13);
      dp_if.nsel = 2'b00; dp_if.loadb = 1'b1; cycle();   // B = R0 too
      dp_if.loads = 1'b1; cycle();
      check("cmp_eq_status", 16'(dp_if.status), 16'h4);

      // ---- MVN : ~0x00F0, C and status in the same cycle ---------------------
      wr_reg(3'd4, 16'h00F0);
      set_ir(16'hB804);                 // op=11 Rm=4
      dp_if.nsel = 2'b10; dp_if.loadb = 1'b1; cycle();
      dp_if.loadc = 1'b1; dp_if.loads = 1'b1; cycle();
      check("mvn_c",      dp_if.c_out,       16'hFF0F);
      check("mvn_status", 16'(dp_if.status), 16'h2);

      // ---- MOV with ASR, asel=1 : 0 + (0x8000 >>> 1) = 0xC000 ----------------
      wr_reg(3'd5, 16'h8000);
      set_ir(16'hC01D);                 // op=00 shift=11 Rm=5
      dp_if.nsel = 2'b10; dp_if.loadb = 1'b1; cycle();
      dp_if.asel = 1'b1; dp_if.loadc = 1'b1; cycle();
      check("asr_c", dp_if.c_out, 16'hC000);
      cycle();
      check("c_hold", dp_if.c_out, 16'hC000);

      // ---- LDR address : 0x0010 + sximm5(0x1F = -1) = 0x000F -----------------
      wr_reg(3'd6, 16'h0010);
      set_ir(16'h661F);                 // Rn=6 imm5=11111
      dp_if.nsel = 2'b00; dp_if.loada = 1'b1; cycle();
      dp_if.bsel = 1'b1; dp_if.loadc = 1'b1; cycle();
      check("ldr_addr", dp_if.c_out, 16'h000F);

      // ---- Read-before-write hazard on R2 -----------------------------------
      wr_reg(3'd2, 16'h0009);           // leaves Rn=2 in IR
      dp_if.mdata = 16'h0005;
      dp_if.nsel  = 2'b00; dp_if.vsel = 2'b00;
      dp_if.write = 1'b1;  dp_if.loadb = 1'b1;
      cycle();
      check("haz_b_old", dp_if.b_out, 16'h0009);
      rd_reg("haz_r2_new", 3'd2, 16'h0005);

      // ---- Reset mid-instruction --------------------------------------------
      wr_reg(3'd7, 16'h9234);
      set_ir(16'h0700);                 // op=00 Rn=7
      dp_if.nsel = 2'b00; dp_if.loada = 1'b1; dp_if.loadb = 1'b1; cycle();
      dp_if.loadc = 1'b1; dp_if.loads = 1'b1; cycle();
      check("pre_rst_c",      dp_if.c_out,       16'h2468);
      check("pre_rst_status", 16'(dp_if.status), 16'h1);
      set_ir(16'hA36A);                 // nonzero opcode/op before reset
      reset = 1'b1;
      dp_if.nsel = 2'b01; dp_if.vsel = 2'b01; dp_if.write = 1'b1;  // R3 <- sximm8
      dp_if.loadc = 1'b1; dp_if.loads = 1'b1; dp_if.loadb = 1'b1;
      cycle();
      check("mid_rst_opcode", 16'(dp_if.opcode), 16'h0);
      check("mid_rst_op",     16'(dp_if.op),     16'h0);
      check("mid_rst_c",      dp_if.c_out,       16'h0);
      check("mid_rst_b",      dp_if.b_out,       16'h0);
      check("mid_rst_status", 16'(dp_if.status), 16'h0);
      rd_reg("mid_rst_r3", 3'd3, 16'h0);
      rd_reg("mid_rst_r7", 3'd7, 16'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_cpu_datapath
